div_const_seq: RTL

DIV_CONST_SEQ -- requirements
Module: div_const_seq

---
 rtl/div_const_pkg.sv | 35 +++
 rtl/div_const_step.sv | 35 +++
 rtl/div_const_seq.sv | 127 ++++++++++++
 3 files changed

// File: rtl/div_const_pkg.sv
// div_const_pkg
// Shared definitions for the sequential constant divider.
//   state_e     : FSM encoding (IDLE / BUSY / DONE)
//   ceil_log2   : ceiling log2 helper usable in constant expressions
//   rem_bits    : remainder width needed for a given divisor
//   step_count  : number of chunk iterations for a dividend width
package div_const_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int ceil_log2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << w) < 64'(value)) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

    // Remainder is always < divisor, so ceil(log2(divisor)) bits suffice.
    function automatic int rem_bits(input int divisor);
        return ceil_log2(divisor);
    endfunction

    function automatic int step_count(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/div_const_step.sv
// div_const_step
// One long-division step by a constant: appends CHUNK dividend bits to the
// running remainder and produces the CHUNK-bit quotient digit and the new
// remainder. Purely combinational.
//   r       : in  RW     running remainder (always < DIVISOR)
//   chunk   : in  CHUNK  next dividend bits, MSB first
//   q_chunk : out CHUNK  quotient digit for this step
//   r_next  : out RW     updated remainder
module div_const_step
    import div_const_pkg::*;
#(
    parameter int DIVISOR = 3,
    parameter int CHUNK   = 8,
    localparam int RW     = rem_bits(DIVISOR)
) (
    input  logic [RW-1:0]    r,
    input  logic [CHUNK-1:0] chunk,
    output logic [CHUNK-1:0] q_chunk,
    output logic [RW-1:0]    r_next
);

    localparam int            TW    = RW + CHUNK;
    localparam logic [TW-1:0] DIV_T = TW'(DIVISOR);

    logic [TW-1:0] t;

    // Because r < DIVISOR, t < DIVISOR << CHUNK, so the quotient digit
    // always fits in CHUNK bits and the casts below drop only zero bits.
    always_comb begin
        t       = {r, chunk};
        q_chunk = CHUNK'(t / DIV_T);
        r_next  = RW'(t % DIV_T);
    end

endmodule

// File: rtl/div_const_seq.sv
// div_const_seq
// Sequential unsigned divider by a constant, consuming CHUNK dividend bits
// per cycle. A dividend is accepted with a valid/ready handshake, processed
// over WIDTH/CHUNK BUSY cycles and presented until the consumer takes it.
//   clk       : in  1      clock, rising edge
//   rst_n     : in  1      asynchronous active-low reset
//   in_valid  : in  1      in_x holds a dividend
//   in_ready  : out 1      ready to accept a dividend (IDLE only)
//   in_x      : in  WIDTH  unsigned dividend
//   out_valid : out 1      out_q/out_r hold a result (DONE only)
//   out_ready : in  1      consumer takes the result
//   out_q     : out WIDTH  floor(in_x / DIVISOR)
//   out_r     : out RW     in_x mod DIVISOR
module div_const_seq
    import div_const_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int DIVISOR = 3,
    parameter int CHUNK   = 8,
    localparam int RW     = rem_bits(DIVISOR)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic [RW-1:0]    out_r
);

    localparam int            STEPS = step_count(WIDTH, CHUNK);
    localparam int            CW    = (STEPS > 1) ? ceil_log2(STEPS) : 1;
    localparam logic [CW-1:0] LAST  = CW'(STEPS - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [CHUNK-1:0] q_chunk;
    logic [RW-1:0]    r_next;

    div_const_step #(
        .DIVISOR (DIVISOR),
        .CHUNK   (CHUNK)
    ) u_step (
        .r       (rem_q),
        .chunk   (shift_q[WIDTH-1 -: CHUNK]),
        .q_chunk (q_chunk),
        .r_next  (r_next)
    );

    // Acceptance is gated by the registered in_ready so the handshake seen
    // outside always matches what the FSM does (including the first cycle
    // after reset, where in_ready is still low).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        shift_d = shift_q;
        quot_d  = quot_q;

        case (state_q)
            ST_IDLE: begin
                if (in_ready_q && in_valid) begin
                    shift_d = in_x;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                rem_d   = r_next;
                quot_d  = (quot_q << CHUNK) | WIDTH'(q_chunk);
                shift_d = shift_q << CHUNK;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            shift_q     <= '0;
            quot_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            shift_q     <= shift_d;
            quot_q      <= quot_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_q     = quot_q;
    assign out_r     = rem_q;

endmodule
